ecc_secded_codec: RTL and testbench
===================================

# ecc_secded_codec

Parametrised single-error-correct / double-error-detect (extended Hamming) encoder and pipelined decoder for memory-controller data paths. It supersedes the fixed 8-bit, 4-check-bit detect-only codec. It adds correction, double-error detection, a valid/ready decode pipeline, saturating error counters and a first-error address log. It sits between the controller write/read data paths and the memory array.

## Interface
- DATA_W, 8: data bits per word (4..64).
- ADDR_W, 16: width of the address tag carried with each decode request.
- CNT_W, 8: width of the error counters.
- R (derived): smallest r with 2^r >= DATA_W + r + 1; 4 for DATA_W=8.
- CODE_W (derived): DATA_W + R + 1; 13 for DATA_W=8.

- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enc_valid_i  in  1  encode request.
- enc_data_i  in  DATA_W  data to encode.
- enc_valid_o  out  1  encoded word valid.
- enc_code_o  out  CODE_W  encoded word.
- dec_valid_i  in  1  decode request.
- dec_ready_o  out  1  decoder accepts a request.
- dec_code_i  in  CODE_W  received word.
- dec_addr_i  in  ADDR_W  address tag.
- dec_valid_o  out  1  decode result valid.
- dec_ready_i  in  1  downstream accepts the result.
- dec_data_o  out  DATA_W  corrected data.
- dec_addr_o  out  ADDR_W  tag travelling with the result.
- dec_ce_o  out  1  single error corrected.
- dec_ue_o  out  1  uncorrectable (double) error.
- clr_i  in  1  clear counters and log.
- ce_cnt_o  out  CNT_W  corrected-error count.
- ue_cnt_o  out  CNT_W  uncorrectable-error count.
- log_valid_o  out  1  log holds an error.
- log_addr_o  out  ADDR_W  address of the first error since clear.
- log_ue_o  out  1  that first error was uncorrectable.

## Operation
- **Codeword layout:**
  - code[0] is the overall parity, equal to the XOR of code[CODE_W-1:1].
  - Positions 1..CODE_W-1 form a Hamming code. Power-of-two positions carry check bits. The remaining positions carry data in ascending order, so data[0] sits at position 3.
  - Check bit at position 2^k is the XOR of all data positions whose index has bit k set.
- **Encode:** no backpressure. When enc_valid_i is high, enc_code_o is registered and enc_valid_o is high on the next cycle; otherwise enc_valid_o is low.
- **Decode, stage 1:** computes and registers the syndrome s (R bits), the overall parity p, the raw word and the tag.
- **Decode, stage 2:** classifies the word and registers the result.
  - s=0, p=0: clean.
  - p=1: single error. Flip the bit at position s (s=0 means code[0]) and assert dec_ce_o.
  - s!=0, p=0: uncorrectable. Assert dec_ue_o and pass the data uncorrected.
- **Flow control:**
  - adv = !dec_valid_o || dec_ready_i.
  - dec_ready_o = adv.
  - Both stages advance only when adv is high. Bubbles propagate as invalid.
- **Counters:**
  - ce_cnt_o / ue_cnt_o increment on an output handshake (dec_valid_o && dec_ready_i) carrying dec_ce_o / dec_ue_o.
  - Both saturate at all-ones.
- **Log:**
  - On the first output-handshake error while log_valid_o is low, capture the tag and the UE flag and set log_valid_o.
  - The log is sticky until clr_i.
- **clr_i:** zeroes the counters and clears the log. It takes priority over an error handshake in the same cycle; that event is neither counted nor logged.

## Timing
- Reset (rst_n low at an edge) drives low or zero: enc_valid_o, enc_code_o, dec_valid_o, dec_data_o, dec_addr_o, dec_ce_o, dec_ue_o, counters, log_valid_o, log_addr_o, log_ue_o.
- Reset discards in-flight words and holds no state.
- Encode latency is 1 cycle.
- Decode latency is 2 cycles from the input handshake to dec_valid_o with no stall. Throughput is 1 word/cycle.
- With dec_valid_o high and dec_ready_i low, all decode outputs hold stable and dec_ready_o is low.
- dec_ready_o is combinational from dec_ready_i; there is no other input-to-output combinational path.
- dec_ce_o and dec_ue_o are never high together.

## Structure
- Package ecc_secded_pkg holds:
  - function ecc_r(DATA_W) for R.
  - function ecc_encode(data) returning the CODE_W word; shared by the encoder and the stage-1 syndrome computation.
  - function ecc_syndrome(code).
- One sub-module, ecc_err_stats, holds the counters, the log and the clear priority. The pipeline stays in the top level.

## Test plan
- DATA_W=8: encode 0x00 -> 13'h0000 one cycle later. Decode it -> data 0x00, ce=0, ue=0 after 2 cycles.
- Encode 0xA5, flip code bit 3 (data[0]), decode with addr 0x0042:
  - data 0xA5, ce=1;
  - ce_cnt=1;
  - log_valid=1, log_addr=0x0042, log_ue=0.
- Encode 0xFF, flip bits 5 and 9:
  - ue=1, ue_cnt=1;
  - log unchanged if already set, otherwise log_ue=1.
- Flip only code[0]: data intact, ce=1.
- Hold dec_ready_i low for 5 cycles with 3 words sent:
  - outputs stable and dec_ready_o low;
  - all 3 results emerge in order once released.
- Preload ce_cnt to 255 via 255 CE words, then send one more CE word: count stays 255.
- Pulse clr_i on the same cycle as a UE handshake: ue_cnt=0, log_valid=0.
- Assert rst_n low mid-stream: all outputs zero at the next edge.

Source files
------------

// File: rtl/ecc_secded_pkg.sv
// Shared SECDED helpers: check-bit count, extended-Hamming encode, data extraction and syndrome.
// Functions work on maximum-width vectors so one package serves every DATA_W up to 64.
package ecc_secded_pkg;

  localparam int DMAX_W = 64;
  localparam int RMAX   = 7;
  localparam int CMAX_W = DMAX_W + RMAX + 1;

  function automatic int ecc_r(input int data_w);
    int r;
    r = RMAX;
    for (int i = RMAX; i >= 1; i--) begin
      if ((1 << i) >= data_w + i + 1) r = i;
    end
    return r;
  endfunction

  function automatic logic is_pow2(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  function automatic logic [CMAX_W-1:0] ecc_encode(input logic [DMAX_W-1:0] data,
                                                   input int data_w);
    logic [CMAX_W-1:0] code;
    int                di;
    int                code_w;
    code   = '0;
    di     = 0;
    code_w = data_w + ecc_r(data_w) + 1;
    for (int pos = 1; pos < CMAX_W; pos++) begin
      if (pos < code_w && !is_pow2(pos)) begin
        code[pos] = data[di];
        di++;
      end
    end
    // Each check bit covers the data positions whose index has its bit set.
    for (int k = 0; k < RMAX; k++) begin
      for (int pos = 1; pos < CMAX_W; pos++) begin
        if (pos < code_w && !is_pow2(pos) && ((pos >> k) & 1) != 0 && (1 << k) < code_w)
          code[1 << k] = code[1 << k] ^ code[pos];
      end
    end
    code[0] = ^code[CMAX_W-1:1];
    return code;
  endfunction

  function automatic logic [DMAX_W-1:0] ecc_extract(input logic [CMAX_W-1:0] code,
                                                    input int data_w);
    logic [DMAX_W-1:0] data;
    int                di;
    int                code_w;
    data   = '0;
    di     = 0;
    code_w = data_w + ecc_r(data_w) + 1;
    for (int pos = 1; pos < CMAX_W; pos++) begin
      if (pos < code_w && !is_pow2(pos)) begin
        data[di] = code[pos];
        di++;
      end
    end
    return data;
  endfunction

  function automatic logic [RMAX-1:0] ecc_syndrome(input logic [CMAX_W-1:0] code,
                                                   input int data_w);
    logic [CMAX_W-1:0] ref_code;
    logic [RMAX-1:0]   s;
    int                code_w;
    code_w   = data_w + ecc_r(data_w) + 1;
    ref_code = ecc_encode(ecc_extract(code, data_w), data_w);
    s        = '0;
    for (int k = 0; k < RMAX; k++) begin
      if ((1 << k) < code_w) s[k] = code[1 << k] ^ ref_code[1 << k];
    end
    return s;
  endfunction

endpackage

// File: rtl/ecc_secded_codec_stats.sv
// Error statistics: saturating CE/UE counters and a sticky first-error log.
// A clear in the same cycle as an error handshake wins; that error is dropped.
module ecc_err_stats
  import ecc_secded_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              evt_i,
  input  logic              ce_i,
  input  logic              ue_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [CNT_W-1:0]  ce_cnt_o,
  output logic [CNT_W-1:0]  ue_cnt_o,
  output logic              log_valid_o,
  output logic [ADDR_W-1:0] log_addr_o,
  output logic              log_ue_o
);

  logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d, ue_cnt_q, ue_cnt_d;
  logic              log_vld_q, log_vld_d, log_ue_q, log_ue_d;
  logic [ADDR_W-1:0] log_addr_q, log_addr_d;

  always_comb begin
    ce_cnt_d   = ce_cnt_q;
    ue_cnt_d   = ue_cnt_q;
    log_vld_d  = log_vld_q;
    log_ue_d   = log_ue_q;
    log_addr_d = log_addr_q;
    if (clr_i) begin
      ce_cnt_d   = '0;
      ue_cnt_d   = '0;
      log_vld_d  = 1'b0;
      log_ue_d   = 1'b0;
      log_addr_d = '0;
    end else if (evt_i) begin
      if (ce_i && ce_cnt_q != '1) ce_cnt_d = ce_cnt_q + CNT_W'(1);
      if (ue_i && ue_cnt_q != '1) ue_cnt_d = ue_cnt_q + CNT_W'(1);
      if ((ce_i || ue_i) && !log_vld_q) begin
        log_vld_d  = 1'b1;
        log_ue_d   = ue_i;
        log_addr_d = addr_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ce_cnt_q   <= '0;
      ue_cnt_q   <= '0;
      log_vld_q  <= 1'b0;
      log_ue_q   <= 1'b0;
      log_addr_q <= '0;
    end else begin
      ce_cnt_q   <= ce_cnt_d;
      ue_cnt_q   <= ue_cnt_d;
      log_vld_q  <= log_vld_d;
      log_ue_q   <= log_ue_d;
      log_addr_q <= log_addr_d;
    end
  end

  assign ce_cnt_o    = ce_cnt_q;
  assign ue_cnt_o    = ue_cnt_q;
  assign log_valid_o = log_vld_q;
  assign log_addr_o  = log_addr_q;
  assign log_ue_o    = log_ue_q;

endmodule

// File: rtl/ecc_secded_codec.sv
// SECDED codec: single-cycle registered encoder and a two-stage valid/ready decoder
// (syndrome, then classify/correct) feeding the error statistics block.
module ecc_secded_codec
  import ecc_secded_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 16,
  parameter  int CNT_W  = 8,
  localparam int R      = ecc_r(DATA_W),
  localparam int CODE_W = DATA_W + R + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enc_valid_i,
  input  logic [DATA_W-1:0] enc_data_i,
  output logic              enc_valid_o,
  output logic [CODE_W-1:0] enc_code_o,
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [CODE_W-1:0] dec_code_i,
  input  logic [ADDR_W-1:0] dec_addr_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [DATA_W-1:0] dec_data_o,
  output logic [ADDR_W-1:0] dec_addr_o,
  output logic              dec_ce_o,
  output logic              dec_ue_o,
  input  logic              clr_i,
  output logic [CNT_W-1:0]  ce_cnt_o,
  output logic [CNT_W-1:0]  ue_cnt_o,
  output logic              log_valid_o,
  output logic [ADDR_W-1:0] log_addr_o,
  output logic              log_ue_o
);

  logic              adv;
  logic              enc_vld_q, enc_vld_d;
  logic [CODE_W-1:0] enc_code_q, enc_code_d;
  logic              vld_p1_q, vld_p1_d, par_p1_q, par_p1_d;
  logic [R-1:0]      syn_p1_q, syn_p1_d;
  logic [CODE_W-1:0] code_p1_q, code_p1_d;
  logic [ADDR_W-1:0] addr_p1_q, addr_p1_d;
  logic              vld_p2_q, vld_p2_d, ce_p2_q, ce_p2_d, ue_p2_q, ue_p2_d;
  logic [DATA_W-1:0] data_p2_q, data_p2_d;
  logic [ADDR_W-1:0] addr_p2_q, addr_p2_d;
  logic [CODE_W-1:0] corr_c;
  logic              ce_c, ue_c;

  // Classification of the stage-1 word; odd parity means one flipped bit at index s.
  always_comb begin
    ce_c   = 1'b0;
    ue_c   = 1'b0;
    corr_c = code_p1_q;
    if (par_p1_q) begin
      ce_c   = 1'b1;
      corr_c = code_p1_q ^ (CODE_W'(1) << syn_p1_q);
    end else if (syn_p1_q != '0) begin
      ue_c   = 1'b1;
    end
  end

  always_comb begin
    adv        = !vld_p2_q || dec_ready_i;
    enc_vld_d  = enc_valid_i;
    enc_code_d = enc_valid_i ? CODE_W'(ecc_encode(DMAX_W'(enc_data_i), DATA_W)) : enc_code_q;
    vld_p1_d   = vld_p1_q;
    syn_p1_d   = syn_p1_q;
    par_p1_d   = par_p1_q;
    code_p1_d  = code_p1_q;
    addr_p1_d  = addr_p1_q;
    vld_p2_d   = vld_p2_q;
    data_p2_d  = data_p2_q;
    addr_p2_d  = addr_p2_q;
    ce_p2_d    = ce_p2_q;
    ue_p2_d    = ue_p2_q;
    if (adv) begin
      // stage 1: syndrome and overall parity of the received word
      vld_p1_d  = dec_valid_i;
      syn_p1_d  = R'(ecc_syndrome(CMAX_W'(dec_code_i), DATA_W));
      par_p1_d  = ^dec_code_i;
      code_p1_d = dec_code_i;
      addr_p1_d = dec_addr_i;
      // stage 2: corrected data and error flags
      vld_p2_d  = vld_p1_q;
      data_p2_d = DATA_W'(ecc_extract(CMAX_W'(corr_c), DATA_W));
      addr_p2_d = addr_p1_q;
      ce_p2_d   = vld_p1_q && ce_c;
      ue_p2_d   = vld_p1_q && ue_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_vld_q  <= 1'b0;
      enc_code_q <= '0;
      vld_p1_q   <= 1'b0;
      syn_p1_q   <= '0;
      par_p1_q   <= 1'b0;
      code_p1_q  <= '0;
      addr_p1_q  <= '0;
      vld_p2_q   <= 1'b0;
      data_p2_q  <= '0;
      addr_p2_q  <= '0;
      ce_p2_q    <= 1'b0;
      ue_p2_q    <= 1'b0;
    end else begin
      enc_vld_q  <= enc_vld_d;
      enc_code_q <= enc_code_d;
      vld_p1_q   <= vld_p1_d;
      syn_p1_q   <= syn_p1_d;
      par_p1_q   <= par_p1_d;
      code_p1_q  <= code_p1_d;
      addr_p1_q  <= addr_p1_d;
      vld_p2_q   <= vld_p2_d;
      data_p2_q  <= data_p2_d;
      addr_p2_q  <= addr_p2_d;
      ce_p2_q    <= ce_p2_d;
      ue_p2_q    <= ue_p2_d;
    end
  end

  assign enc_valid_o = enc_vld_q;
  assign enc_code_o  = enc_code_q;
  assign dec_ready_o = adv;
  assign dec_valid_o = vld_p2_q;
  assign dec_data_o  = data_p2_q;
  assign dec_addr_o  = addr_p2_q;
  assign dec_ce_o    = ce_p2_q;
  assign dec_ue_o    = ue_p2_q;

  ecc_err_stats #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr_i),
    .evt_i      (vld_p2_q && dec_ready_i),
    .ce_i       (ce_p2_q),
    .ue_i       (ue_p2_q),
    .addr_i     (addr_p2_q),
    .ce_cnt_o   (ce_cnt_o),
    .ue_cnt_o   (ue_cnt_o),
    .log_valid_o(log_valid_o),
    .log_addr_o (log_addr_o),
    .log_ue_o   (log_ue_o)
  );

endmodule

// File: tb/tb_ecc_secded_codec.sv
// Bench for ecc_secded_codec (DATA_W=8): directed cases plus randomized traffic against
// a position-table reference model, an in-order result scoreboard and counter/log model.
module tb_ecc_secded_codec;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 8;
  localparam int CODE_W = 13;
  localparam int DPOS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic              ce;
    logic              ue;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n, enc_valid_i, enc_valid_o, dec_valid_i, dec_ready_o;
  logic              dec_valid_o, dec_ready_i, dec_ce_o, dec_ue_o, clr_i;
  logic              log_valid_o, log_ue_o;
  logic [DATA_W-1:0] enc_data_i, dec_data_o;
  logic [CODE_W-1:0] enc_code_o, dec_code_i;
  logic [ADDR_W-1:0] dec_addr_i, dec_addr_o, log_addr_o;
  logic [CNT_W-1:0]  ce_cnt_o, ue_cnt_o;

  int checks = 0;
  int errors = 0;

  res_t              expq[$];
  logic              m_enc_vld = 1'b0;
  logic [CODE_W-1:0] m_enc_code = '0;
  logic [CNT_W-1:0]  m_ce = '0, m_ue = '0;
  logic              m_log_vld = 1'b0, m_log_ue = 1'b0;
  logic [ADDR_W-1:0] m_log_addr = '0;
  logic              prev_stall = 1'b0;
  res_t              prev_out;
  bit                done;

  always #5 clk = ~clk;

  ecc_secded_codec #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .enc_valid_i(enc_valid_i), .enc_data_i(enc_data_i),
    .enc_valid_o(enc_valid_o), .enc_code_o(enc_code_o),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_code_i(dec_code_i), .dec_addr_i(dec_addr_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_data_o(dec_data_o), .dec_addr_o(dec_addr_o),
    .dec_ce_o(dec_ce_o), .dec_ue_o(dec_ue_o),
    .clr_i(clr_i), .ce_cnt_o(ce_cnt_o), .ue_cnt_o(ue_cnt_o),
    .log_valid_o(log_valid_o), .log_addr_o(log_addr_o), .log_ue_o(log_ue_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference encode: data to non-power-of-two slots; check bits are the XOR of set slot indices.
  function automatic logic [CODE_W-1:0] model_enc(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    int                h;
    c = '0;
    h = 0;
    for (int j = 0; j < DATA_W; j++) begin
      if (d[j]) begin
        c[DPOS[j]] = 1'b1;
        h = h ^ DPOS[j];
      end
    end
    c[1] = h[0];
    c[2] = h[1];
    c[4] = h[2];
    c[8] = h[3];
    c[0] = ^c[CODE_W-1:1];
    return c;
  endfunction

  function automatic res_t model_dec(input logic [CODE_W-1:0] cw, input logic [ADDR_W-1:0] a);
    res_t r;
    int   s;
    int   p;
    s = 0;
    p = 0;
    for (int i = 0; i < CODE_W; i++) begin
      if (cw[i]) begin
        p = p ^ 1;
        s = s ^ i;
      end
    end
    r.ce = 1'b0;
    r.ue = 1'b0;
    if (p == 1) begin
      r.ce = 1'b1;
      if (s < CODE_W) cw[s] = ~cw[s];
    end else if (s != 0) begin
      r.ue = 1'b1;
    end
    for (int j = 0; j < DATA_W; j++) r.d[j] = cw[DPOS[j]];
    r.a = a;
    return r;
  endfunction

  // Monitor: compares state produced by the last rising edge, then predicts the next one.
  always @(negedge clk) begin
    res_t e;
    bit   hs;
    check_eq("enc_valid", 32'(enc_valid_o), 32'(m_enc_vld));
    check_eq("enc_code", 32'(enc_code_o), 32'(m_enc_code));
    check_eq("ce_cnt", 32'(ce_cnt_o), 32'(m_ce));
    check_eq("ue_cnt", 32'(ue_cnt_o), 32'(m_ue));
    check_eq("log_valid", 32'(log_valid_o), 32'(m_log_vld));
    if (m_log_vld) begin
      check_eq("log_addr", 32'(log_addr_o), 32'(m_log_addr));
      check_eq("log_ue", 32'(log_ue_o), 32'(m_log_ue));
    end
    check_eq("ready_rule", 32'(dec_ready_o), 32'(!dec_valid_o || dec_ready_i));
    check_eq("ce_ue_excl", 32'(dec_ce_o && dec_ue_o), 32'(0));
    if (prev_stall) begin
      check_eq("hold_valid", 32'(dec_valid_o), 32'(1));
      check_eq("hold_out", 32'({dec_data_o, dec_addr_o, dec_ce_o, dec_ue_o}), 32'(prev_out));
    end
    hs = 1'b0;
    e  = '0;
    if (!rst_n) begin
      expq.delete();
      m_enc_vld  = 1'b0;
      m_enc_code = '0;
      m_ce       = '0;
      m_ue       = '0;
      m_log_vld  = 1'b0;
      m_log_ue   = 1'b0;
      m_log_addr = '0;
      prev_stall = 1'b0;
    end else begin
      if (dec_valid_o && dec_ready_i) begin
        check_eq("out_pending", 32'(expq.size() > 0), 32'(1));
        if (expq.size() > 0) begin
          e  = expq.pop_front();
          hs = 1'b1;
          check_eq("dec_data", 32'(dec_data_o), 32'(e.d));
          check_eq("dec_addr", 32'(dec_addr_o), 32'(e.a));
          check_eq("dec_ce", 32'(dec_ce_o), 32'(e.ce));
          check_eq("dec_ue", 32'(dec_ue_o), 32'(e.ue));
        end
      end
      if (dec_valid_i && dec_ready_o) expq.push_back(model_dec(dec_code_i, dec_addr_i));
      if (clr_i) begin
        m_ce      = '0;
        m_ue      = '0;
        m_log_vld = 1'b0;
      end else if (hs && (e.ce || e.ue)) begin
        if (e.ce && m_ce != 8'hFF) m_ce = m_ce + 8'd1;
        if (e.ue && m_ue != 8'hFF) m_ue = m_ue + 8'd1;
        if (!m_log_vld) begin
          m_log_vld  = 1'b1;
          m_log_addr = e.a;
          m_log_ue   = e.ue;
        end
      end
      m_enc_vld = enc_valid_i;
      if (enc_valid_i) m_enc_code = model_enc(enc_data_i);
      prev_stall = dec_valid_o && !dec_ready_i;
      prev_out   = '{d: dec_data_o, a: dec_addr_o, ce: dec_ce_o, ue: dec_ue_o};
    end
  end

  task automatic send_dec(input logic [CODE_W-1:0] c, input logic [ADDR_W-1:0] a);
    int n;
    n           = 0;
    dec_valid_i = 1'b1;
    dec_code_i  = c;
    dec_addr_i  = a;
    @(negedge clk);
    while (!dec_ready_o && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check_eq("send_wait", 32'(n >= 1000), 32'(0));
    @(posedge clk);
    #1;
    dec_valid_i = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [CODE_W-1:0] flip_rand(input logic [CODE_W-1:0] c, input int nerr);
    int p0, p1;
    p0 = $urandom_range(0, CODE_W - 1);
    p1 = (p0 + $urandom_range(1, CODE_W - 1)) % CODE_W;
    if (nerr >= 1) c[p0] = ~c[p0];
    if (nerr >= 2) c[p1] = ~c[p1];
    return c;
  endfunction

  initial begin
    rst_n       = 1'b0;
    enc_valid_i = 1'b0;
    enc_data_i  = '0;
    dec_valid_i = 1'b0;
    dec_code_i  = '0;
    dec_addr_i  = '0;
    dec_ready_i = 1'b1;
    clr_i       = 1'b0;
    done        = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    check_eq("rst_dec_valid", 32'(dec_valid_o), 32'(0));
    check_eq("rst_enc_valid", 32'(enc_valid_o), 32'(0));
    check_eq("rst_log_valid", 32'(log_valid_o), 32'(0));
    check_eq("rst_cnt", 32'({ce_cnt_o, ue_cnt_o}), 32'(0));

    // Encode 0x00, then decode it and confirm two-cycle latency.
    enc_valid_i = 1'b1;
    enc_data_i  = 8'h00;
    cycles(1);
    enc_valid_i = 1'b0;
    check_eq("enc00_valid", 32'(enc_valid_o), 32'(1));
    check_eq("enc00_code", 32'(enc_code_o), 32'(13'h0000));
    send_dec(13'h0000, 16'h0000);
    @(negedge clk);
    check_eq("lat1_valid", 32'(dec_valid_o), 32'(0));
    @(negedge clk);
    check_eq("lat2_valid", 32'(dec_valid_o), 32'(1));
    check_eq("lat2_data", 32'(dec_data_o), 32'(8'h00));
    cycles(2);

    // Single error in data[0] of 0xA5.
    enc_valid_i = 1'b1;
    enc_data_i  = 8'hA5;
    cycles(1);
    enc_valid_i = 1'b0;
    send_dec(model_enc(8'hA5) ^ 13'h0008, 16'h0042);
    cycles(3);
    check_eq("a5_ce_cnt", 32'(ce_cnt_o), 32'(1));
    check_eq("a5_log", 32'({log_valid_o, log_addr_o, log_ue_o}), 32'({1'b1, 16'h0042, 1'b0}));

    // Double error on 0xFF; log keeps the earlier CE entry.
    send_dec(model_enc(8'hFF) ^ 13'h0220, 16'h0077);
    cycles(3);
    check_eq("ff_ue_cnt", 32'(ue_cnt_o), 32'(1));
    check_eq("ff_log_addr", 32'(log_addr_o), 32'(16'h0042));

    // Overall parity bit only.
    send_dec(model_enc(8'h3C) ^ 13'h0001, 16'h0003);
    cycles(3);
    check_eq("p0_ce_cnt", 32'(ce_cnt_o), 32'(2));

    // Backpressure: three words, downstream stalled for five cycles.
    dec_ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) send_dec(model_enc(8'(8'h10 + i)), 16'(16'h0100 + i));
      end
      begin
        cycles(5);
        check_eq("stall_ready", 32'(dec_ready_o), 32'(0));
        dec_ready_i = 1'b1;
      end
    join
    cycles(4);
    check_eq("stall_drain", 32'(expq.size()), 32'(0));

    // Saturation of the CE counter.
    for (int i = 0; i < 256; i++) send_dec(flip_rand(model_enc(8'($urandom)), 1), 16'(i));
    cycles(4);
    check_eq("ce_sat", 32'(ce_cnt_o), 32'(255));

    // Clear coincident with a UE handshake.
    send_dec(model_enc(8'h5A) ^ 13'h0006, 16'h0BAD);
    cycles(1);
    clr_i = 1'b1;
    cycles(1);
    clr_i = 1'b0;
    check_eq("clr_ue_cnt", 32'(ue_cnt_o), 32'(0));
    check_eq("clr_log_valid", 32'(log_valid_o), 32'(0));

    // Randomized traffic with random backpressure, encodes and clears.
    fork
      begin
        for (int i = 0; i < 300; i++)
          send_dec(flip_rand(model_enc(8'($urandom)), $urandom_range(0, 2)), 16'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          cycles(1);
          dec_ready_i = ($urandom_range(0, 3) != 0);
        end
        dec_ready_i = 1'b1;
      end
      begin
        while (!done) begin
          cycles(1);
          enc_valid_i = 1'($urandom_range(0, 1));
          enc_data_i  = 8'($urandom);
          clr_i       = ($urandom_range(0, 39) == 0);
        end
        clr_i       = 1'b0;
        enc_valid_i = 1'b0;
      end
    join
    cycles(6);
    check_eq("rand_drain", 32'(expq.size()), 32'(0));

    // Reset with words and an encode in flight.
    enc_valid_i = 1'b1;
    enc_data_i  = 8'h5A;
    send_dec(model_enc(8'h11) ^ 13'h0010, 16'h0201);
    send_dec(model_enc(8'h22), 16'h0202);
    rst_n = 1'b0;
    cycles(1);
    check_eq("mrst_dec", 32'({dec_valid_o, dec_data_o, dec_addr_o, dec_ce_o, dec_ue_o}), 32'(0));
    check_eq("mrst_enc", 32'({enc_valid_o, enc_code_o}), 32'(0));
    check_eq("mrst_stats", 32'({ce_cnt_o, ue_cnt_o, log_valid_o, log_ue_o}), 32'(0));
    check_eq("mrst_log_addr", 32'(log_addr_o), 32'(0));
    rst_n       = 1'b1;
    enc_valid_i = 1'b0;
    cycles(4);
    check_eq("mrst_no_output", 32'(dec_valid_o), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
